// File: rtl/anubis_pkg.sv
// Shared definitions for the pi permutation pipeline.
//   PiDefN / PiDefW / PiDefStages : default matrix dimension, element width, pipeline depth
//   pi_mode_e                     : permutation mode (PI_FWD = pi, PI_INV = inverse pi)
package anubis_pkg;

  localparam int unsigned PiDefN      = 4;
  localparam int unsigned PiDefW      = 8;
  localparam int unsigned PiDefStages = 2;

  typedef enum logic {
    PI_FWD = 1'b0,
    PI_INV = 1'b1
  } pi_mode_e;

endpackage

// File: rtl/pi_perm_comb.sv
// Combinational pi / inverse-pi permutation of an N x N matrix of W-bit elements.
// Element (i,j) lives at bits [W*(N*i+j) +: W].
//   in_matrix  : source matrix
//   inv        : mode, PI_FWD: out(i,j) = in((i-j) mod N, j); PI_INV: out(i,j) = in((i+j) mod N, j)
//   out_matrix : permuted matrix
module pi_perm_comb
  import anubis_pkg::*;
#(
  parameter int unsigned N = PiDefN,
  parameter int unsigned W = PiDefW
) (
  input  logic [N*N*W-1:0] in_matrix,
  input  logic             inv,
  output logic [N*N*W-1:0] out_matrix
);

  logic is_inv;
  assign is_inv = (pi_mode_e'(inv) == PI_INV);

  // Source rows are elaboration-time constants, so this is pure wiring plus a 2:1 mux.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      localparam int unsigned FwdRow = (i + N - j) % N;
      localparam int unsigned InvRow = (i + j) % N;
      assign out_matrix[W*(N*i+j) +: W] = is_inv ? in_matrix[W*(N*InvRow+j) +: W]
                                                 : in_matrix[W*(N*FwdRow+j) +: W];
    end
  end

endmodule

// File: rtl/pi_perm_pipe.sv
// Pipelined pi / inverse-pi matrix permutation with valid/ready handshakes on both sides.
// The permutation is applied before slot 0; later slots only carry data.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake; in_ready does not depend on in_valid
//   in_inv              : per-word mode (0 = pi, 1 = inverse pi)
//   in_matrix           : N*N*W input matrix
//   out_valid/out_ready : output handshake
//   out_matrix          : permuted matrix
//   stall_cnt           : saturating count of out_valid && !out_ready cycles when built with
//                         PI_STALL_CNT_EN defined, otherwise tied to 0
module pi_perm_pipe
  import anubis_pkg::*;
#(
  parameter int unsigned N      = PiDefN,
  parameter int unsigned W      = PiDefW,
  parameter int unsigned STAGES = PiDefStages
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [N*N*W-1:0] in_matrix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] out_matrix,
  output logic [31:0]      stall_cnt
);

  localparam int unsigned MW = N * N * W;

  logic [MW-1:0] perm_matrix;

  pi_perm_comb #(
    .N(N),
    .W(W)
  ) u_perm (
    .in_matrix (in_matrix),
    .inv       (in_inv),
    .out_matrix(perm_matrix)
  );

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] mode_q;
  logic [MW-1:0]     data_q   [STAGES];
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_mode;
  logic [MW-1:0]     src_data [STAGES];

  // A slot loads when empty or when its content moves on; this ripples back from the output.
  always_comb begin
    logic chain;
    load           = '0;
    chain          = !valid_q[STAGES-1] || out_ready;
    load[STAGES-1] = chain;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      chain   = !valid_q[k] || chain;
      load[k] = chain;
    end
  end

  always_comb begin
    src_valid    = '0;
    src_mode     = '0;
    src_data     = '{default: '0};
    src_valid[0] = in_valid;
    src_mode[0]  = in_inv;
    src_data[0]  = perm_matrix;
    for (int k = 1; k < int'(STAGES); k++) begin
      src_valid[k] = valid_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_data[k]  = data_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (load[k]) valid_q[k] <= src_valid[k];
      end
    end
  end

  // Payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(STAGES); k++) begin
      if (load[k]) begin
        data_q[k] <= src_data[k];
        mode_q[k] <= src_mode[k];
      end
    end
  end

  // Mode already took effect before slot 0; the last slot's copy has no consumer.
  logic unused_mode;
  assign unused_mode = mode_q[STAGES-1];

  assign in_ready   = load[0] && !rst;
  assign out_valid  = valid_q[STAGES-1] && !rst;
  assign out_matrix = rst ? '0 : data_q[STAGES-1];

`ifdef PI_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
